audio_capture_link: RTL and testbench

//  Return path of the mic effects board: drains ADC samples from the codec Audio_Controller,

---
 rtl/audio_link_pkg.sv | 14 +
 rtl/sample_fifo.sv | 85 ++++++++
 rtl/audio_capture_link.sv | 134 +++++++++++++
 tb/tb_audio_capture_link.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_link_pkg.sv
// Shared types and defaults for the audio capture/playback links.
// Contents: cap_state_e (capture FSM state), SAMPLE_W_DEF, FIFO_DEPTH_DEF.
package audio_link_pkg;

    localparam int unsigned SAMPLE_W_DEF   = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through sample FIFO.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i, din_i     write request and data (ignored when full unless popping)
//   pop_i             read request (ignored when empty)
//   full_c, empty_c   combinational occupancy flags
//   dout_o            registered head word; holds last value when empty
//   valid_o           registered "dout_o holds an unread word"
module sample_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         full_c,
    output logic         empty_c,
    output logic [W-1:0] dout_o,
    output logic         valid_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          push_ok_c;
    logic          pop_ok_c;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CW'(DEPTH));

    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    assign pop_ok_c  = pop_i && !empty_c;
    assign push_ok_c = push_i && (!full_c || pop_ok_c);

    // Pointer/count/output next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        valid_d  = !empty_c;
        if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (!empty_c) dout_d = mem_q[rd_ptr_q];
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = dout_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/audio_capture_link.sv
// Codec ADC -> STM32 return path: drains L/R pairs from the codec controller,
// buffers sample words in a FIFO and presents them on a strobe-to-read port.
// Optional build macro: AUDIO_CAPTURE_MONO_MIX_EN (sample word = mean of L and R;
// otherwise the left channel is used and the right channel ignored).
// Ports:
//   CLOCK_50, reset                  clock, synchronous active-high reset
//   audio_in_available               codec has an ADC pair ready
//   left/right_channel_audio_in      codec ADC samples
//   read_audio_in                    one-cycle pop strobe to the codec
//   AUDIO_RD                         asynchronous STM32 read strobe (rising edge pops)
//   AUDIO_OUT, AUDIO_VALID           FIFO head sample and its valid flag
//   AUDIO_OVERFLOW                   sticky sample-dropped flag
module audio_capture_link
    import audio_link_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = SAMPLE_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                audio_in_available,
    input  logic [SAMPLE_W-1:0] left_channel_audio_in,
    input  logic [SAMPLE_W-1:0] right_channel_audio_in,
    output logic                read_audio_in,
    input  logic                AUDIO_RD,
    output logic [SAMPLE_W-1:0] AUDIO_OUT,
    output logic                AUDIO_VALID,
    output logic                AUDIO_OVERFLOW
);

    cap_state_e          state_q, state_d;
    logic                read_q, read_d;
    logic [SAMPLE_W-1:0] word_q, word_d;
    logic                ovf_q, ovf_d;
    logic                push_c;
    logic                pop_c;
    logic                fifo_full_c;
    logic                fifo_empty_c;
    logic [SAMPLE_W-1:0] mix_word_c;
    logic                rd_sync1_q, rd_sync2_q, rd_edge_q;

    // Sample word selection.
`ifdef AUDIO_CAPTURE_MONO_MIX_EN
    logic [SAMPLE_W:0] mix_sum_c;
    // Sign-extended sum cannot overflow; arithmetic shift of the sum floors the mean.
    assign mix_sum_c  = {left_channel_audio_in[SAMPLE_W-1], left_channel_audio_in}
                      + {right_channel_audio_in[SAMPLE_W-1], right_channel_audio_in};
    assign mix_word_c = SAMPLE_W'(mix_sum_c >> 1);
`else
    logic unused_right_c;
    assign unused_right_c = ^right_channel_audio_in;
    assign mix_word_c     = left_channel_audio_in;
`endif

    // AUDIO_RD synchroniser and rising-edge detect.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rd_sync1_q <= 1'b0;
            rd_sync2_q <= 1'b0;
            rd_edge_q  <= 1'b0;
        end else begin
            rd_sync1_q <= AUDIO_RD;
            rd_sync2_q <= rd_sync1_q;
            rd_edge_q  <= rd_sync2_q;
        end
    end

    assign pop_c = rd_sync2_q && !rd_edge_q;

    // Capture FSM next-state and outputs.
    always_comb begin
        state_d = state_q;
        read_d  = 1'b0;
        word_d  = word_q;
        ovf_d   = ovf_q;
        push_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (audio_in_available) begin
                    state_d = READ;
                    read_d  = 1'b1;
                end
            end
            READ: begin
                word_d  = mix_word_c;
                state_d = WRITE;
            end
            WRITE: begin
                // Always drain the codec; drop the word if no slot frees this cycle.
                push_c  = 1'b1;
                if (fifo_full_c && !pop_c) ovf_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            word_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
        end
    end

    sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst     (reset),
        .push_i  (push_c),
        .din_i   (word_q),
        .pop_i   (pop_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .dout_o  (AUDIO_OUT),
        .valid_o (AUDIO_VALID)
    );

    logic unused_empty_c;
    assign unused_empty_c = fifo_empty_c;

    assign read_audio_in  = read_q;
    assign AUDIO_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_audio_capture_link.sv
// Directed self-checking bench for audio_capture_link.
module tb_audio_capture_link;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        audio_in_available;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        read_audio_in;
    logic        AUDIO_RD;
    logic [15:0] AUDIO_OUT;
    logic        AUDIO_VALID;
    logic        AUDIO_OVERFLOW;

    int checks = 0;
    int errors = 0;
    int n_reads = 0;
    int base;

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) if (read_audio_in) n_reads <= n_reads + 1;

    audio_capture_link dut (
        .CLOCK_50               (CLOCK_50),
        .reset                  (reset),
        .audio_in_available     (audio_in_available),
        .left_channel_audio_in  (left_in),
        .right_channel_audio_in (right_in),
        .read_audio_in          (read_audio_in),
        .AUDIO_RD               (AUDIO_RD),
        .AUDIO_OUT              (AUDIO_OUT),
        .AUDIO_VALID            (AUDIO_VALID),
        .AUDIO_OVERFLOW         (AUDIO_OVERFLOW)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Offer one pair, wait (bounded) for the pop strobe, then let it reach the FIFO output.
    task automatic send(input logic [15:0] lv, input logic [15:0] rv);
        int i;
        logic got;
        left_in = lv;
        right_in = rv;
        audio_in_available = 1'b1;
        got = 1'b0;
        i = 0;
        while (!got && i < 10) begin
            @(negedge CLOCK_50);
            if (read_audio_in) got = 1'b1;
            i++;
        end
        audio_in_available = 1'b0;
        if (!got) check("read_timeout", 32'd0, 32'd1);
        cyc(3);
    endtask

    task automatic rd_pulse();
        AUDIO_RD = 1'b1;
        cyc(4);
        AUDIO_RD = 1'b0;
        cyc(4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    initial begin
        reset = 1'b1;
        audio_in_available = 1'b0;
        AUDIO_RD = 1'b0;
        left_in = '0;
        right_in = '0;

        // 1. reset state, idle codec
        cyc(3);
        check("rst_read", 32'(read_audio_in), 32'd0);
        check("rst_valid", 32'(AUDIO_VALID), 32'd0);
        check("rst_out", 32'(AUDIO_OUT), 32'd0);
        check("rst_ovf", 32'(AUDIO_OVERFLOW), 32'd0);
        reset = 1'b0;
        base = n_reads;
        cyc(20);
        check("idle_no_reads", 32'(n_reads - base), 32'd0);
        check("idle_valid", 32'(AUDIO_VALID), 32'd0);

        // 2. single pair latency
        base = n_reads;
        left_in = 16'h1234;
        right_in = 16'h1236;
        audio_in_available = 1'b1;
        cyc(1);
        check("t1_read_high", 32'(read_audio_in), 32'd1);
        audio_in_available = 1'b0;
        cyc(1);
        check("t2_read_low", 32'(read_audio_in), 32'd0);
        check("t2_valid", 32'(AUDIO_VALID), 32'd0);
        cyc(1);
        check("t3pre_valid", 32'(AUDIO_VALID), 32'd0);
        cyc(1);
        check("t3_valid", 32'(AUDIO_VALID), 32'd1);
`ifdef AUDIO_CAPTURE_MONO_MIX_EN
        check("t3_out", 32'(AUDIO_OUT), 32'h1235);
`else
        check("t3_out", 32'(AUDIO_OUT), 32'h1234);
`endif
        check("t3_one_read", 32'(n_reads - base), 32'd1);
        rd_pulse();
        check("t3_drained", 32'(AUDIO_VALID), 32'd0);

        // 3. mix sign handling (left-only build passes L straight through)
        send(16'h8000, 16'hFFFF);
`ifdef AUDIO_CAPTURE_MONO_MIX_EN
        check("mix_neg", 32'(AUDIO_OUT), 32'hBFFF);
`else
        check("mix_neg", 32'(AUDIO_OUT), 32'h8000);
`endif
        rd_pulse();
        send(16'h7FFF, 16'h7FFF);
        check("mix_pos", 32'(AUDIO_OUT), 32'h7FFF);
        rd_pulse();

        // 4. overflow with 9 pushes into depth 8
        do_reset();
        base = n_reads;
        for (int v = 1; v <= 9; v++) send(16'(v), 16'(v));
        check("ovf_set", 32'(AUDIO_OVERFLOW), 32'd1);
        check("ovf_reads", 32'(n_reads - base), 32'd9);
        check("ovf_valid", 32'(AUDIO_VALID), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("drain_out", 32'(AUDIO_OUT), 32'(i));
            check("drain_valid", 32'(AUDIO_VALID), 32'd1);
            rd_pulse();
        end
        check("drain_empty", 32'(AUDIO_VALID), 32'd0);
        check("drain_hold", 32'(AUDIO_OUT), 32'd8);
        check("ovf_sticky", 32'(AUDIO_OVERFLOW), 32'd1);

        // 5. held RD pops once; pops when empty are ignored
        do_reset();
        check("rst_clears_ovf", 32'(AUDIO_OVERFLOW), 32'd0);
        send(16'h000A, 16'h000A);
        send(16'h000B, 16'h000B);
        send(16'h000C, 16'h000C);
        AUDIO_RD = 1'b1;
        cyc(50);
        AUDIO_RD = 1'b0;
        cyc(4);
        check("held_out", 32'(AUDIO_OUT), 32'h000B);
        check("held_valid", 32'(AUDIO_VALID), 32'd1);
        rd_pulse();
        check("pop2_out", 32'(AUDIO_OUT), 32'h000C);
        rd_pulse();
        check("pop3_valid", 32'(AUDIO_VALID), 32'd0);
        rd_pulse();
        rd_pulse();
        check("empty_pop_valid", 32'(AUDIO_VALID), 32'd0);
        check("empty_pop_hold", 32'(AUDIO_OUT), 32'h000C);

        // 6a. pop coincident with WRITE at full
        do_reset();
        for (int i = 0; i < 8; i++) send(16'(32'h20 + i), 16'(32'h20 + i));
        check("full_head", 32'(AUDIO_OUT), 32'h20);
        check("full_no_ovf", 32'(AUDIO_OVERFLOW), 32'd0);
        left_in = 16'h0028;
        right_in = 16'h0028;
        audio_in_available = 1'b1;
        AUDIO_RD = 1'b1;
        cyc(1);
        check("coinc_read", 32'(read_audio_in), 32'd1);
        audio_in_available = 1'b0;
        cyc(6);
        AUDIO_RD = 1'b0;
        cyc(4);
        check("coinc_no_ovf", 32'(AUDIO_OVERFLOW), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            check("coinc_out", 32'(AUDIO_OUT), 32'(32'h20 + i));
            check("coinc_valid", 32'(AUDIO_VALID), 32'd1);
            rd_pulse();
        end
        check("coinc_empty", 32'(AUDIO_VALID), 32'd0);

        // 6b. reset while in READ
        send(16'h0055, 16'h0055);
        check("pre_rst_valid", 32'(AUDIO_VALID), 32'd1);
        left_in = 16'h0066;
        right_in = 16'h0066;
        audio_in_available = 1'b1;
        cyc(1);
        check("in_read", 32'(read_audio_in), 32'd1);
        reset = 1'b1;
        audio_in_available = 1'b0;
        cyc(1);
        check("abort_read", 32'(read_audio_in), 32'd0);
        check("abort_valid", 32'(AUDIO_VALID), 32'd0);
        check("abort_out", 32'(AUDIO_OUT), 32'd0);
        reset = 1'b0;
        base = n_reads;
        cyc(5);
        check("abort_no_push", 32'(AUDIO_VALID), 32'd0);
        check("abort_no_reads", 32'(n_reads - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
